// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data, occupancy, programmable almost flags, sticky errors.
// Read latency 1 clk; no backpressure: a write into a full FIFO is dropped, and a read from an empty FIFO is refused, each setting a sticky error.
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_RESET   = 6,
  parameter int AE_RESET   = 2
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic                  thr_load,
  input  logic [ADDR_WIDTH:0]   af_thr_in,
  input  logic [ADDR_WIDTH:0]   ae_thr_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_udf_q, err_udf_d;
  logic [CW-1:0]         af_thr_q, af_thr_d;
  logic [CW-1:0]         ae_thr_q, ae_thr_d;
  logic                  wr_ok, rd_ok, ovf_evt, udf_evt;

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= af_thr_q);
  assign almost_empty = (count_q <= ae_thr_q);

  always_comb begin
    // A read on a full FIFO frees the slot the same-cycle write reuses.
    wr_ok   = fifo_wr & (~fifo_full | fifo_rd);
    rd_ok   = fifo_rd & ~fifo_empty;
    ovf_evt = fifo_wr & fifo_full & ~fifo_rd;
    udf_evt = fifo_rd & fifo_empty;

    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    af_thr_d     = af_thr_q;
    ae_thr_d     = ae_thr_q;

    if (wr_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      data_out_d   = mem_q[rd_ptr_q];
      rd_ptr_d     = rd_ptr_q + 1'b1;
      data_valid_d = 1'b1;
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new error in the clear cycle wins over the clear.
    err_ovf_d = (err_clr ? 1'b0 : err_ovf_q) | ovf_evt;
    err_udf_d = (err_clr ? 1'b0 : err_udf_q) | udf_evt;

    if (thr_load) begin
      af_thr_d = af_thr_in;
      ae_thr_d = ae_thr_in;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_udf_q    <= 1'b0;
      af_thr_q     <= CW'(AF_RESET);
      ae_thr_q     <= CW'(AE_RESET);
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      err_ovf_q    <= err_ovf_d;
      err_udf_q    <= err_udf_d;
      af_thr_q     <= af_thr_d;
      ae_thr_q     <= ae_thr_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = data_valid_q;
  assign count         = count_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       RESET_L = 1'b0;
  logic [5:0] data_in = '0;
  logic       fifo_wr = 1'b0;
  logic       fifo_rd = 1'b0;
  logic       thr_load = 1'b0;
  logic [3:0] af_thr_in = '0;
  logic [3:0] ae_thr_in = '0;
  logic       err_clr = 1'b0;
  logic [5:0] data_out;
  logic       data_valid, fifo_empty, fifo_full, almost_full, almost_empty;
  logic [3:0] count;
  logic       err_overflow, err_underflow;

  int checks = 0;
  int failures = 0;

  fifo_param dut (
    .clk(clk), .RESET_L(RESET_L), .data_in(data_in), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .thr_load(thr_load), .af_thr_in(af_thr_in), .ae_thr_in(ae_thr_in), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a queue of words.
  logic [5:0] m_q[$];
  int         m_af = 6, m_ae = 2;
  logic [5:0] m_dout = '0;
  logic       m_dvld = 1'b0, m_eo = 1'b0, m_eu = 1'b0;

  always @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      m_q.delete();
      m_af = 6; m_ae = 2;
      m_dout = '0; m_dvld = 1'b0; m_eo = 1'b0; m_eu = 1'b0;
    end else begin
      int  n;
      bit  full, empty, ovf, udf;
      n     = m_q.size();
      full  = (n == 8);
      empty = (n == 0);
      ovf   = fifo_wr && full && !fifo_rd;
      udf   = fifo_rd && empty;
      if (fifo_rd && !empty) begin
        m_dout = m_q.pop_front();
        m_dvld = 1'b1;
      end else begin
        m_dvld = 1'b0;
      end
      if (fifo_wr && (!full || fifo_rd)) m_q.push_back(data_in);
      m_eo = (err_clr ? 1'b0 : m_eo) | ovf;
      m_eu = (err_clr ? 1'b0 : m_eu) | udf;
      if (thr_load) begin
        m_af = int'(af_thr_in);
        m_ae = int'(ae_thr_in);
      end
    end
  end

  always @(negedge clk) begin
    if (RESET_L) begin
      int n;
      n = m_q.size();
      check("count", count, n);
      check("fifo_empty", fifo_empty, n == 0);
      check("fifo_full", fifo_full, n == 8);
      check("almost_full", almost_full, n >= m_af);
      check("almost_empty", almost_empty, n <= m_ae);
      check("data_valid", data_valid, m_dvld);
      check("data_out", data_out, m_dout);
      check("err_overflow", err_overflow, m_eo);
      check("err_underflow", err_underflow, m_eu);
    end
  end

  task automatic step(input bit w, input bit r, input logic [5:0] d);
    fifo_wr = w; fifo_rd = r; data_in = d;
    @(posedge clk);
    #1;
    fifo_wr = 1'b0; fifo_rd = 1'b0; thr_load = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    #12 RESET_L = 1'b1;
    @(posedge clk); #1;

    check("rst_count", count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_dv", data_valid, 0);

    // 1: fill, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 6'(i));
      check("s1_af", almost_full, i >= 6);
    end
    check("s1_count8", count, 8);
    check("s1_full", fifo_full, 1);
    step(1, 0, 6'h09);
    check("s1_ovf", err_overflow, 1);
    check("s1_count_hold", count, 8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0);
      check("s1_rd_data", data_out, i);
      check("s1_rd_vld", data_valid, 1);
    end
    check("s1_empty", fifo_empty, 1);

    // 2: simultaneous read/write while full
    for (int i = 1; i <= 8; i++) step(1, 0, 6'(i));
    step(1, 1, 6'h2A);
    check("s2_dout", data_out, 6'h01);
    check("s2_dv", data_valid, 1);
    check("s2_count", count, 8);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    check("s2_last", data_out, 6'h2A);

    // 3: simultaneous read/write while empty
    step(1, 1, 6'h15);
    check("s3_udf", err_underflow, 1);
    check("s3_dv", data_valid, 0);
    check("s3_count", count, 1);
    step(0, 1, 0);
    check("s3_dout", data_out, 6'h15);

    // 4: pointer wrap
    for (int i = 0; i < 5; i++) step(1, 0, 6'(i + 16));
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 6'(8'h30 + i));
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      check("s4_order", data_out, 32'h30 + i);
    end
    check("s4_empty", fifo_empty, 1);

    // 5: thresholds and error clear
    thr_load = 1'b1; af_thr_in = 4'd3; ae_thr_in = 4'd0;
    step(0, 0, 0);
    step(1, 0, 6'h11);
    check("s5_ae_off", almost_empty, 0);
    step(1, 0, 6'h12);
    check("s5_af_2", almost_full, 0);
    step(1, 0, 6'h13);
    check("s5_af_3", almost_full, 1);
    err_clr = 1'b1;
    step(0, 0, 0);
    check("s5_eo_clr", err_overflow, 0);
    check("s5_eu_clr", err_underflow, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) step(1, 0, 6'(i + 32));
    step(1, 1, 6'h25);
    check("s6_pre_count", count, 5);
    #2 RESET_L = 1'b0;
    #1;
    check("s6_count", count, 0);
    check("s6_empty", fifo_empty, 1);
    check("s6_dv", data_valid, 0);
    check("s6_eo", err_overflow, 0);
    check("s6_eu", err_underflow, 0);
    #3 RESET_L = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 6'h3C);
    check("s6_mem0", dut.mem_q[0], 6'h3C);
    step(0, 1, 0);
    check("s6_rd", data_out, 6'h3C);

    // Random traffic with occasional threshold loads and error clears
    for (int i = 0; i < 3000; i++) begin
      int wbias;
      wbias = (i / 300) % 2 ? 35 : 70;
      if ($urandom_range(99) < 4) begin
        thr_load  = 1'b1;
        af_thr_in = 4'($urandom_range(15));
        ae_thr_in = 4'($urandom_range(15));
      end
      err_clr = ($urandom_range(99) < 5);
      step($urandom_range(99) < wbias, $urandom_range(99) < 50, 6'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the 6-bit, 8-deep channel FIFO.
- Generalised in data width and depth (power of two).
- Adds the following:
  - true simultaneous read/write;
  - registered read data with a valid strobe;
  - occupancy output;
  - programmable almost-full/almost-empty flags;
  - sticky overflow/underflow errors.
- Sits between the packet-routing front end and the per-channel consumers.
- Used as the standard buffer for every channel in the datapath.

Parameters:
- DATA_WIDTH, 6, width of each stored word.
- ADDR_WIDTH, 3, pointer width; depth DEPTH = 2**ADDR_WIDTH (default 8).
- AF_RESET, 6, reset value of the almost-full threshold register.
- AE_RESET, 2, reset value of the almost-empty threshold register.

Ports:
- clk  in  1  single clock, all state on rising edge.
- RESET_L  in  1  asynchronous active-low reset.
- data_in  in  DATA_WIDTH  write data.
- fifo_wr  in  1  write request.
- fifo_rd  in  1  read request.
- thr_load  in  1  load almost_full_thr/almost_empty_thr from thr_in inputs this cycle.
- af_thr_in  in  ADDR_WIDTH+1  new almost-full threshold.
- ae_thr_in  in  ADDR_WIDTH+1  new almost-empty threshold.
- err_clr  in  1  clears sticky error bits.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  data_out holds a word popped on the previous edge.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- almost_full  out  1  count >= af_thr.
- almost_empty  out  1  count <= ae_thr.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- err_overflow  out  1  sticky: write attempted while full and not relieved by a same-cycle read.
- err_underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (RESET_L low, asynchronous, takes effect immediately, also mid-transfer):
  - wr_ptr, rd_ptr, count, data_out all 0.
  - data_valid=0, err_overflow=0, err_underflow=0.
  - af_thr=AF_RESET, ae_thr=AE_RESET.
  - Stored words are not cleared.
  - Flags after reset: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
- Storage: internal DEPTH x DATA_WIDTH register array. Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Qualified strobes, evaluated on pre-edge state:
  - wr_ok = fifo_wr & (~fifo_full | fifo_rd)
  - rd_ok = fifo_rd & ~fifo_empty
- Write: on wr_ok, mem[wr_ptr] <= data_in and wr_ptr++.
- Read: on rd_ok, data_out <= mem[rd_ptr], rd_ptr++, data_valid <= 1.
  - Otherwise data_valid <= 0 and data_out holds its value.
  - Read latency is 1 clock: request at edge N, data_out/data_valid valid after edge N.
- Count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither.
- Full + rd + wr: both accepted; the oldest word is popped and the new word is written into the freed slot; count stays DEPTH; no error.
- Empty + rd + wr: write accepted, read rejected; err_underflow set; count becomes 1; data_valid=0. There is no fall-through.
- Overflow: fifo_wr & fifo_full & ~fifo_rd drops the word; pointers and count are unchanged; err_overflow <= 1.
- Underflow: fifo_rd & fifo_empty leaves pointers unchanged; err_underflow <= 1.
- Error bits:
  - Sticky until err_clr.
  - err_clr has priority over a new set in the same cycle only if no new error occurs. If an error occurs in the same cycle, the bit stays 1.
- Flags fifo_empty, fifo_full, almost_full and almost_empty are combinational from count and the threshold registers. They have no glitch requirement beyond synchronous use.
- Thresholds:
  - thr_load registers both thresholds on the edge; the new values apply to flags from the next cycle.
  - Values above DEPTH are legal: almost_full then never asserts, almost_empty is always asserted.

Test Plan (DATA_WIDTH=6, ADDR_WIDTH=3):
1. Reset, then write 0x01..0x08 on 8 consecutive cycles:
   - count=8, fifo_full=1, almost_full=1 from count 6.
   - 9th write 0x09 -> err_overflow=1, count stays 8.
   - Subsequent reads return 0x01..0x08; 0x09 is never returned.
2. Full FIFO, fifo_rd=fifo_wr=1 with data 0x2A:
   - data_out=0x01, data_valid=1, count=8, no error.
   - After 8 more reads the last word read is 0x2A.
3. Empty FIFO, fifo_rd=fifo_wr=1 with 0x15:
   - err_underflow=1, data_valid=0, count=1.
   - Next read gives data_out=0x15.
4. Wrap-around: write 5, read 5, then write 0x30..0x37 and read 8:
   - Order 0x30..0x37 is preserved.
   - rd_ptr/wr_ptr wrap with no loss; fifo_empty=1 at the end.
5. thr_load with af=3, ae=0:
   - After 3 writes almost_full=1; almost_empty=0 from first write.
   - err_clr pulse clears sticky errors from scenario 1.
6. Assert RESET_L low asynchronously mid-burst, between edges, with count=5:
   - count=0, fifo_empty=1, data_valid=0 and errors clear immediately, before the next edge.
   - First write after release lands at address 0.
